// File: rtl/display_pkg.sv
// Shared display constants and the slice sequencer state encoding.
//   SCAN_RATE : default column pairs per angular slice
//   NUM_COLS  : total columns across both panel halves
//   NUM_ROWS  : rows per panel column
//   RGB_RES   : bits per colour channel
//   seq_state_t : sequencer FSM states
package display_pkg;

  localparam int SCAN_RATE = 32;
  localparam int NUM_COLS  = 2 * SCAN_RATE;
  localparam int NUM_ROWS  = 32;
  localparam int RGB_RES   = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_SCAN    = 2'd2,
    ST_HOLD    = 2'd3
  } seq_state_t;

endpackage

// File: rtl/rotation_period_meter.sv
// Measures the rotation period between hall pulses and derives the
// per-slice time budget.
//   i_clk               : system clock
//   i_rst               : synchronous active-high reset
//   i_hall              : one-cycle pulse per revolution
//   i_run               : counter advances while high (sequencer not idle)
//   o_count_sat         : period counter has reached all-ones
//   o_slice_period      : latched period divided by the slice count
//   o_next_slice_period : slice period that would be latched this cycle
module rotation_period_meter #(
  parameter int NUM_SLICES = 64,
  parameter int PERIOD_W   = 24
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_hall,
  input  logic                i_run,
  output logic                o_count_sat,
  output logic [PERIOD_W-1:0] o_slice_period,
  output logic [PERIOD_W-1:0] o_next_slice_period
);

  localparam int SLICE_SH = $clog2(NUM_SLICES);

  logic [PERIOD_W-1:0] r_count;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] w_next_period;

  assign o_count_sat = &r_count;
  // count+1 is held at all-ones so a saturated count cannot wrap to a tiny period
  assign w_next_period       = o_count_sat ? r_count : r_count + PERIOD_W'(1);
  assign o_next_slice_period = w_next_period >> SLICE_SH;
  assign o_slice_period      = r_period >> SLICE_SH;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count  <= '0;
      r_period <= '0;
    end else begin
      if (i_hall) begin
        r_count  <= '0;
        r_period <= w_next_period;
      end else if (i_run && !o_count_sat) begin
        r_count <= r_count + PERIOD_W'(1);
      end
    end
  end

endmodule

// File: rtl/slice_sequencer.sv
// Angular slice sequencer for a rotating display: locks to the hall
// pulse period, splits each revolution into slices and streams the
// column pairs of each slice over a valid/ready handshake.
//   clk_in            : system clock
//   rst_in            : synchronous active-high reset
//   hall_in           : one-cycle pulse per revolution (synchronized)
//   col_ready_in      : downstream accepts the current column pair
//   col_valid_out     : column pair outputs are valid
//   column_index1_out : left-half column 0..SCAN_RATE-1
//   column_index2_out : right-half column SCAN_RATE..2*SCAN_RATE-1
//   slice_out         : current angular slice
//   slice_start_out   : pulse on first cycle of each slice
//   locked_out        : rotation period measured and usable
//   overrun_out       : pulse when a slice scan exceeded its budget
module slice_sequencer #(
  parameter int SCAN_RATE  = display_pkg::SCAN_RATE,
  parameter int NUM_SLICES = 64,
  parameter int PERIOD_W   = 24
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          hall_in,
  input  logic                          col_ready_in,
  output logic                          col_valid_out,
  output logic [$clog2(SCAN_RATE)-1:0]  column_index1_out,
  output logic [$clog2(SCAN_RATE):0]    column_index2_out,
  output logic [$clog2(NUM_SLICES)-1:0] slice_out,
  output logic                          slice_start_out,
  output logic                          locked_out,
  output logic                          overrun_out
);

  import display_pkg::*;

  localparam int KW = $clog2(SCAN_RATE);
  localparam int SW = $clog2(NUM_SLICES);
  localparam logic [KW-1:0] K_LAST = KW'(SCAN_RATE - 1);

  seq_state_t          r_state;
  logic [KW-1:0]       r_k;
  logic [KW:0]         r_col2;
  logic [SW-1:0]       r_slice;
  logic [PERIOD_W-1:0] r_timer;
  logic                r_valid;
  logic                r_start;
  logic                r_locked;
  logic                r_overrun;
  logic                r_expired;
  logic                r_resync;
  logic                r_unlock;

  seq_state_t          w_state_nxt;
  logic [KW-1:0]       w_k_nxt;
  logic [SW-1:0]       w_slice_nxt;
  logic [PERIOD_W-1:0] w_timer_nxt;
  logic                w_valid_nxt;
  logic                w_start_nxt;
  logic                w_locked_nxt;
  logic                w_overrun_nxt;
  logic                w_expired_nxt;
  logic                w_resync_nxt;
  logic                w_unlock_nxt;

  logic                w_do_start;
  logic [SW-1:0]       w_start_slice;
  logic                w_do_drop;
  seq_state_t          w_drop_state;

  logic                w_sat;
  logic [PERIOD_W-1:0] w_slice_period;
  logic [PERIOD_W-1:0] w_next_slice_period;
  logic                w_short;
  logic                w_expire;
  logic                w_xfer;

  rotation_period_meter #(
    .NUM_SLICES (NUM_SLICES),
    .PERIOD_W   (PERIOD_W)
  ) u_meter (
    .i_clk               (clk_in),
    .i_rst               (rst_in),
    .i_hall              (hall_in),
    .i_run               (r_state != ST_IDLE),
    .o_count_sat         (w_sat),
    .o_slice_period      (w_slice_period),
    .o_next_slice_period (w_next_slice_period)
  );

  assign w_short  = w_next_slice_period < PERIOD_W'(SCAN_RATE);
  assign w_expire = r_timer == (w_slice_period - PERIOD_W'(1));
  assign w_xfer   = r_valid & col_ready_in;

  always_comb begin
    w_state_nxt   = r_state;
    w_k_nxt       = r_k;
    w_slice_nxt   = r_slice;
    w_timer_nxt   = '0;
    w_valid_nxt   = r_valid;
    w_start_nxt   = 1'b0;
    w_locked_nxt  = r_locked;
    w_overrun_nxt = 1'b0;
    w_expired_nxt = r_expired;
    w_resync_nxt  = r_resync;
    w_unlock_nxt  = r_unlock;
    w_do_start    = 1'b0;
    w_start_slice = '0;
    w_do_drop     = 1'b0;
    w_drop_state  = ST_IDLE;

    case (r_state)
      ST_IDLE: begin
        if (hall_in) w_state_nxt = ST_MEASURE;
      end

      ST_MEASURE: begin
        if (hall_in) begin
          if (!w_short) begin
            w_do_start   = 1'b1;
            w_locked_nxt = 1'b1;
          end
        end else if (w_sat) begin
          w_do_drop = 1'b1;
        end
      end

      // No pair is outstanding here, so every event acts immediately.
      ST_HOLD: begin
        w_timer_nxt = r_timer + PERIOD_W'(1);
        if (hall_in) begin
          if (w_short) begin
            w_do_drop    = 1'b1;
            w_drop_state = ST_MEASURE;
          end else begin
            w_do_start = 1'b1;
          end
        end else if (w_sat) begin
          w_do_drop = 1'b1;
        end else if (w_expire) begin
          w_do_start    = 1'b1;
          w_start_slice = r_slice + SW'(1);
        end
      end

      // Events are remembered until the pending pair transfers; the
      // newest hall decides whether the period is still usable, and a
      // resync outranks a timer expiry so it never reports an overrun.
      ST_SCAN: begin
        w_timer_nxt   = r_timer + PERIOD_W'(1);
        w_resync_nxt  = r_resync | hall_in;
        w_unlock_nxt  = hall_in ? w_short : r_unlock;
        w_expired_nxt = r_expired | w_expire;
        if (w_xfer) begin
          if (w_sat && !hall_in) begin
            w_do_drop = 1'b1;
          end else if (w_unlock_nxt) begin
            w_do_drop    = 1'b1;
            w_drop_state = ST_MEASURE;
          end else if (w_resync_nxt) begin
            w_do_start = 1'b1;
          end else if (w_expired_nxt) begin
            w_do_start    = 1'b1;
            w_start_slice = r_slice + SW'(1);
            w_overrun_nxt = 1'b1;
          end else if (r_k == K_LAST) begin
            w_state_nxt = ST_HOLD;
            w_valid_nxt = 1'b0;
          end else begin
            w_k_nxt = r_k + KW'(1);
          end
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_do_start) begin
      w_state_nxt   = ST_SCAN;
      w_slice_nxt   = w_start_slice;
      w_k_nxt       = '0;
      w_valid_nxt   = 1'b1;
      w_start_nxt   = 1'b1;
      w_timer_nxt   = '0;
      w_expired_nxt = 1'b0;
      w_resync_nxt  = 1'b0;
      w_unlock_nxt  = 1'b0;
    end

    if (w_do_drop) begin
      w_state_nxt   = w_drop_state;
      w_slice_nxt   = '0;
      w_k_nxt       = '0;
      w_valid_nxt   = 1'b0;
      w_locked_nxt  = 1'b0;
      w_timer_nxt   = '0;
      w_expired_nxt = 1'b0;
      w_resync_nxt  = 1'b0;
      w_unlock_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= ST_IDLE;
      r_k       <= '0;
      r_col2    <= '0;
      r_slice   <= '0;
      r_timer   <= '0;
      r_valid   <= 1'b0;
      r_start   <= 1'b0;
      r_locked  <= 1'b0;
      r_overrun <= 1'b0;
      r_expired <= 1'b0;
      r_resync  <= 1'b0;
      r_unlock  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_k       <= w_k_nxt;
      r_col2    <= {1'b0, w_k_nxt} + (KW+1)'(SCAN_RATE);
      r_slice   <= w_slice_nxt;
      r_timer   <= w_timer_nxt;
      r_valid   <= w_valid_nxt;
      r_start   <= w_start_nxt;
      r_locked  <= w_locked_nxt;
      r_overrun <= w_overrun_nxt;
      r_expired <= w_expired_nxt;
      r_resync  <= w_resync_nxt;
      r_unlock  <= w_unlock_nxt;
    end
  end

  assign col_valid_out     = r_valid;
  assign column_index1_out = r_k;
  assign column_index2_out = r_col2;
  assign slice_out         = r_slice;
  assign slice_start_out   = r_start;
  assign locked_out        = r_locked;
  assign overrun_out       = r_overrun;

endmodule

// File: doc/slice_sequencer.md
SLICE_SEQUENCER -- requirements
Module: slice_sequencer

Interface
REQ-001: Parameter SCAN_RATE, default 32, meaning column pairs per slice; power of two.
REQ-002: Parameter NUM_SLICES, default 64, meaning angular slices per revolution; power of two.
REQ-003: Parameter PERIOD_W, default 24, meaning rotation-period counter width.
REQ-004: clk_in  input  1  system clock; single clock domain.
REQ-005: rst_in  input  1  reset, synchronous, active-high.
REQ-006: hall_in  input  1  one-cycle pulse per revolution, already synchronized to clk_in.
REQ-007: col_ready_in  input  1  downstream frame/panel path accepts the current column pair.
REQ-008: col_valid_out  output  1  column pair on index outputs is valid.
REQ-009: column_index1_out  output  $clog2(SCAN_RATE)  left-half column, range 0..SCAN_RATE-1.
REQ-010: column_index2_out  output  $clog2(SCAN_RATE)+1  right-half column, range SCAN_RATE..2*SCAN_RATE-1.
REQ-011: slice_out  output  $clog2(NUM_SLICES)  current angular slice.
REQ-012: slice_start_out  output  1  one-cycle pulse on first cycle of each slice.
REQ-013: locked_out  output  1  rotation period measured and valid.
REQ-014: overrun_out  output  1  one-cycle pulse when a slice scan overran its time budget.

Function
REQ-015: States SHALL be IDLE, MEASURE, SCAN, HOLD; all outputs registered.
REQ-016: IDLE: on hall_in, period counter SHALL clear to 0 and state SHALL go to MEASURE.
REQ-017: Period counter SHALL increment every cycle outside IDLE, clear on each hall_in, saturate at all-ones.
REQ-018: On hall_in, period SHALL latch count+1 and slice_period SHALL be period >> log2(NUM_SLICES).
REQ-019: MEASURE on hall_in: if slice_period < SCAN_RATE stay MEASURE; else locked_out=1, slice_out=0, pair k=0, slice_start_out pulse, go SCAN.
REQ-020: Counter saturation SHALL force IDLE, locked_out=0, col_valid_out=0 at the next handshake boundary.
REQ-021: SCAN: col_valid_out=1, column_index1_out=k, column_index2_out=k+SCAN_RATE (zero-extended add).
REQ-022: Handshake: transfer on col_valid_out&col_ready_in; index outputs SHALL hold stable and valid SHALL NOT drop until transfer.
REQ-023: On transfer, k SHALL increment; transfer of k=SCAN_RATE-1 SHALL go HOLD with col_valid_out=0 next cycle.
REQ-024: Slice timer SHALL clear at slice start and increment every cycle in SCAN and HOLD.
REQ-025: HOLD: when timer reaches slice_period-1, slice_out SHALL increment (wrap NUM_SLICES-1 to 0), k=0, slice_start_out pulse, go SCAN.
REQ-026: Timer expiry in SCAN: state SHALL remain SCAN until the pending pair transfers, then advance slice, k=0, pulse overrun_out and slice_start_out in the same cycle.
REQ-027: hall_in while locked: latch new period; in HOLD, slice_out=0, k=0, slice_start_out, go SCAN next cycle; in SCAN, resync SHALL be applied at the next transfer.
REQ-028: hall_in coinciding with timer expiry SHALL win: slice_out=0, no increment, no overrun_out.
REQ-029: New slice_period < SCAN_RATE while locked SHALL drop locked_out and go MEASURE at the next handshake boundary.

Reset
REQ-030: rst_in SHALL set state IDLE; col_valid_out, column_index1_out, column_index2_out, slice_out, slice_start_out, locked_out, overrun_out, counters and period all to 0.
REQ-031: rst_in mid-SCAN SHALL drop col_valid_out on the next cycle regardless of col_ready_in.

Structure
REQ-032: SCAN_RATE, NUM_COLS, NUM_ROWS, RGB_RES and the state enum SHALL live in shared package display_pkg.
REQ-033: Period measurement (REQ-017/018, saturation) SHALL be one sub-module, rotation_period_meter.

Verification (SCAN_RATE=4, NUM_SLICES=4)
REQ-034: Reset, hall pulses 100 cycles apart, ready=1 -> locked_out=1 after 2nd pulse, slice_period=25, pairs (0,4),(1,5),(2,6),(3,7) per slice, slice_start_out every 25 cycles, slice_out 0,1,2,3.
REQ-035: Hall 12 cycles apart -> slice_period=3 < 4, locked_out stays 0, col_valid_out stays 0.
REQ-036: ready low for 30 cycles mid-slice -> indices stable, overrun_out one pulse at the transfer, next slice starts with k=0.
REQ-037: No hall after lock -> slice_out wraps 3 to 0 free-running; counter saturation -> IDLE, locked_out=0.
REQ-038: Hall coinciding with HOLD timer expiry -> slice_out=0, overrun_out=0, slice_start_out single pulse.
REQ-039: rst_in asserted with col_valid_out=1, ready=0 -> all outputs 0 next cycle, state IDLE.
